csi_pkt_ctrl: RTL

- Sequences the packet-header finder for one CSI-2 lane pair.
  - Holds the finder in reset between HS bursts.
  - Releases it on burst start.
  - Decodes the 32-bit header word (DI, WC, ECC).
  - Counts long-packet payload bytes and strips the 2-byte CRC.
  - Re-arms the finder after the packet, ready for the next burst.
- Sits between the finder's outputs and the pixel/unpack stage.

---
 rtl/csi_pkg.sv | 48 ++++
 rtl/csi_crc16.sv | 47 ++++
 rtl/csi_pkt_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/csi_pkg.sv
// ---------------------------------------------------------------------------
// csi_pkg
// Shared definitions for the CSI-2 packet controller:
//   - controller state encoding
//   - default short-packet data-type limit and word-count limit
//   - bit positions of DI / WC / ECC and the payload half of the finder word
//   - CRC-16 constants and a one-byte update helper
// ---------------------------------------------------------------------------
package csi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        CRC_LO  = 3'd3,
        CRC_HI  = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    localparam int DT_W    = 6;
    localparam int DI_LSB  = 0;
    localparam int DI_W    = 8;
    localparam int WC_LSB  = 8;
    localparam int WC_W    = 16;
    localparam int ECC_LSB = 24;
    localparam int ECC_W   = 8;
    localparam int PAY_LSB = 16;
    localparam int PAY_W   = 16;

    localparam logic [DT_W-1:0] SHORT_DT_MAX_DEF = 6'h0F;
    localparam logic [WC_W-1:0] WC_MAX_DEF       = 16'd8192;

    // x^16+x^12+x^5+1 in bit-reversed form, for an LSB-first shift register.
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;

    // Shift one byte, LSB first, through the reflected CRC-16 register.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data_byte);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/csi_crc16.sv
// ---------------------------------------------------------------------------
// csi_crc16
// Running CRC-16 over up to two bytes per cycle.
// Ports:
//   rxbyteclkhs  clock
//   reset        asynchronous active-high reset (register -> init value)
//   init         reload the init value this cycle (has priority over en)
//   data[15:0]   two bytes; [7:0] is the earlier byte
//   en[1:0]      per-byte enable; en[0] qualifies data[7:0]
//   crc[15:0]    current register value (covers all bytes accepted so far)
// ---------------------------------------------------------------------------
module csi_crc16
    import csi_pkg::*;
(
    input  logic        rxbyteclkhs,
    input  logic        reset,
    input  logic        init,
    input  logic [15:0] data,
    input  logic [1:0]  en,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc_reg;
        for (int i = 0; i < 2; i++) begin
            if (en[i]) begin
                crc_next = crc16_byte(crc_next, data[i*8 +: 8]);
            end
        end
    end

    always_ff @(posedge rxbyteclkhs or posedge reset) begin
        if (reset) begin
            crc_reg <= CRC_INIT;
        end else if (init) begin
            crc_reg <= CRC_INIT;
        end else begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/csi_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// csi_pkt_ctrl
// Sequences the packet-header finder of one CSI-2 lane pair: keeps the
// finder in reset between HS bursts, decodes the header word, forwards
// long-packet payload two bytes per beat, strips the trailing CRC and
// re-arms the finder for the next burst.
//
// Optional build macro: CSI_PKT_CTRL_CRC_CHECK_EN
//   defined   - payload CRC-16 is checked; crc_err pulses with pkt_done on
//               a mismatch.
//   undefined - CRC bytes are discarded and crc_err is tied low.
//
// Ports:
//   rxbyteclkhs, reset          clock, asynchronous active-high reset
//   rx_active                   HS burst in progress
//   ph_data/ph_valid/ph_select  finder output word, valid, header flag
//   finder_rst                  registered reset to the finder
//   hdr_valid, hdr_di/wc/ecc    header pulse and latched fields
//   pay_data/strb/valid/last    payload beat (earlier byte in [7:0])
//   pkt_done, pkt_err, crc_err  end-of-packet status pulses
// All pulse outputs are registered, one cycle after the causing input beat.
// ---------------------------------------------------------------------------
module csi_pkt_ctrl
    import csi_pkg::*;
#(
    parameter logic [DT_W-1:0] SHORT_DT_MAX = SHORT_DT_MAX_DEF,
    parameter logic [WC_W-1:0] WC_MAX       = WC_MAX_DEF
) (
    input  logic        rxbyteclkhs,
    input  logic        reset,
    input  logic        rx_active,
    input  logic [31:0] ph_data,
    input  logic        ph_valid,
    input  logic        ph_select,
    output logic        finder_rst,
    output logic        hdr_valid,
    output logic [7:0]  hdr_di,
    output logic [15:0] hdr_wc,
    output logic [7:0]  hdr_ecc,
    output logic [15:0] pay_data,
    output logic [1:0]  pay_strb,
    output logic        pay_valid,
    output logic        pay_last,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic        crc_err
);

    state_t      state_reg, state_next;
    logic [15:0] rem_reg, rem_next;
    logic [7:0]  di_reg, di_next;
    logic [15:0] wc_reg, wc_next;
    logic [7:0]  ecc_reg, ecc_next;
    logic [15:0] pay_data_reg, pay_data_next;
    logic [1:0]  pay_strb_reg, pay_strb_next;
    logic        pay_valid_reg, pay_valid_next;
    logic        pay_last_reg, pay_last_next;
    logic        hdr_valid_reg, hdr_valid_next;
    logic        pkt_done_reg, pkt_done_next;
    logic        pkt_err_reg, pkt_err_next;
    logic        finder_rst_reg;
    logic [1:0]  beat_strb;

    // Only the final beat of an odd word count carries a single payload byte.
    assign beat_strb = (rem_reg == 16'd1) ? 2'b01 : 2'b11;

`ifdef CSI_PKT_CTRL_CRC_CHECK_EN
    logic [15:0] crc_value;
    logic [7:0]  crc_lo_reg, crc_lo_next;
    logic        crc_err_reg, crc_err_next;
    logic [1:0]  crc_en;

    assign crc_en = (state_reg == PAYLOAD && rx_active && ph_valid) ? beat_strb : 2'b00;

    csi_crc16 u_crc16 (
        .rxbyteclkhs (rxbyteclkhs),
        .reset       (reset),
        .init        (state_reg == HDR),
        .data        (ph_data[PAY_LSB +: PAY_W]),
        .en          (crc_en),
        .crc         (crc_value)
    );

    always_ff @(posedge rxbyteclkhs or posedge reset) begin
        if (reset) begin
            crc_lo_reg  <= 8'h00;
            crc_err_reg <= 1'b0;
        end else begin
            crc_lo_reg  <= crc_lo_next;
            crc_err_reg <= crc_err_next;
        end
    end

    assign crc_err = crc_err_reg;
`else
    assign crc_err = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        rem_next       = rem_reg;
        di_next        = di_reg;
        wc_next        = wc_reg;
        ecc_next       = ecc_reg;
        pay_data_next  = pay_data_reg;
        pay_strb_next  = pay_strb_reg;
        pay_valid_next = 1'b0;
        pay_last_next  = 1'b0;
        hdr_valid_next = 1'b0;
        pkt_done_next  = 1'b0;
        pkt_err_next   = 1'b0;
`ifdef CSI_PKT_CTRL_CRC_CHECK_EN
        crc_lo_next    = crc_lo_reg;
        crc_err_next   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (rx_active) state_next = HDR;
            end
            DRAIN: begin
                // A new burst must start from IDLE, so wait for rx_active low.
                if (!rx_active) state_next = IDLE;
            end
            default: begin
                if (!rx_active) begin
                    // Burst ended mid-packet; this beats any completion.
                    pkt_err_next = 1'b1;
                    state_next   = IDLE;
                end else if (ph_valid) begin
                    case (state_reg)
                        HDR: begin
                            if (ph_select) begin
                                di_next        = ph_data[DI_LSB +: DI_W];
                                wc_next        = ph_data[WC_LSB +: WC_W];
                                ecc_next       = ph_data[ECC_LSB +: ECC_W];
                                hdr_valid_next = 1'b1;
                                if (ph_data[DI_LSB +: DT_W] <= SHORT_DT_MAX) begin
                                    pkt_done_next = 1'b1;
                                    state_next    = DRAIN;
                                end else if (ph_data[WC_LSB +: WC_W] > WC_MAX) begin
                                    pkt_err_next = 1'b1;
                                    state_next   = DRAIN;
                                end else if (ph_data[WC_LSB +: WC_W] == 16'd0) begin
                                    state_next = CRC_LO;
                                end else begin
                                    rem_next   = ph_data[WC_LSB +: WC_W];
                                    state_next = PAYLOAD;
                                end
                            end
                        end
                        PAYLOAD: begin
                            pay_valid_next = 1'b1;
                            pay_data_next  = ph_data[PAY_LSB +: PAY_W];
                            pay_strb_next  = beat_strb;
                            if (rem_reg > 16'd2) begin
                                rem_next = rem_reg - 16'd2;
                            end else if (rem_reg == 16'd2) begin
                                pay_last_next = 1'b1;
                                state_next    = CRC_LO;
                            end else begin
                                // Upper byte of this beat is already the CRC low byte.
                                pay_last_next = 1'b1;
`ifdef CSI_PKT_CTRL_CRC_CHECK_EN
                                crc_lo_next   = ph_data[31:24];
`endif
                                state_next    = CRC_HI;
                            end
                        end
                        CRC_LO: begin
                            pkt_done_next = 1'b1;
`ifdef CSI_PKT_CTRL_CRC_CHECK_EN
                            crc_err_next  = ({ph_data[31:24], ph_data[23:16]} != crc_value);
`endif
                            state_next    = DRAIN;
                        end
                        CRC_HI: begin
                            pkt_done_next = 1'b1;
`ifdef CSI_PKT_CTRL_CRC_CHECK_EN
                            crc_err_next  = ({ph_data[23:16], crc_lo_reg} != crc_value);
`endif
                            state_next    = DRAIN;
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge rxbyteclkhs or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            rem_reg        <= 16'd0;
            di_reg         <= 8'd0;
            wc_reg         <= 16'd0;
            ecc_reg        <= 8'd0;
            pay_data_reg   <= 16'd0;
            pay_strb_reg   <= 2'b00;
            pay_valid_reg  <= 1'b0;
            pay_last_reg   <= 1'b0;
            hdr_valid_reg  <= 1'b0;
            pkt_done_reg   <= 1'b0;
            pkt_err_reg    <= 1'b0;
            finder_rst_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            rem_reg        <= rem_next;
            di_reg         <= di_next;
            wc_reg         <= wc_next;
            ecc_reg        <= ecc_next;
            pay_data_reg   <= pay_data_next;
            pay_strb_reg   <= pay_strb_next;
            pay_valid_reg  <= pay_valid_next;
            pay_last_reg   <= pay_last_next;
            hdr_valid_reg  <= hdr_valid_next;
            pkt_done_reg   <= pkt_done_next;
            pkt_err_reg    <= pkt_err_next;
            // Follows the current state, so the finder leaves reset one
            // cycle after the controller leaves IDLE.
            finder_rst_reg <= (state_reg == IDLE) || (state_reg == DRAIN);
        end
    end

    assign finder_rst = finder_rst_reg;
    assign hdr_valid  = hdr_valid_reg;
    assign hdr_di     = di_reg;
    assign hdr_wc     = wc_reg;
    assign hdr_ecc    = ecc_reg;
    assign pay_data   = pay_data_reg;
    assign pay_strb   = pay_strb_reg;
    assign pay_valid  = pay_valid_reg;
    assign pay_last   = pay_last_reg;
    assign pkt_done   = pkt_done_reg;
    assign pkt_err    = pkt_err_reg;

endmodule
